// File: rtl/instr_fetch.sv
// Instruction fetch unit: request/ack bus fetch into a small FIFO, presenting
// the head entry (word, PC, fault) to decode with stall and redirect handling.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_IBus_Req,
    output logic [31:0] o_IBus_Addr,
    input  logic        i_IBus_Ack,
    input  logic [31:0] i_IBus_Data,
    input  logic        i_IBus_Err,
    output logic [31:0] o_Instr,
    output logic [31:0] o_Instr_PC,
    output logic        o_Instr_Valid,
    output logic        o_Fetch_Fault,
    input  logic        i_Stall,
    input  logic        i_Redirect,
    input  logic [31:0] i_Redirect_PC
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_KILL, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   redir_pc_q, redir_pc_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   last_pc_q, last_pc_d;

    logic [31:0]          instr_mem_q [BUF_DEPTH];
    logic [31:0]          pc_mem_q    [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] fault_mem_q;

    logic        valid;
    logic        pop;
    logic        room;
    logic        req;
    logic        ack;
    logic        push;
    logic [31:0] push_instr;
    logic [31:0] new_pc;

    always_comb begin
        valid      = (count_q != '0);
        pop        = valid && !i_Stall && !i_Redirect;
        room       = (count_q < DEPTH_CNT) || pop;
        // A raised request is held by pend_q until acked, so a stall that
        // removes the pop-freed slot cannot withdraw it.
        req        = pend_q || ((state_q == S_REQ) && room);
        ack        = req && i_IBus_Ack;
        push       = (state_q == S_REQ) && ack && !i_Redirect;
        push_instr = i_IBus_Err ? NOP_INSTR : i_IBus_Data;
        new_pc     = i_Redirect_PC & ~32'h3;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        redir_pc_d = redir_pc_q;
        pend_d     = req && !ack;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (ack) begin
                    if (i_IBus_Err) begin
                        state_d = S_HALT;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            S_KILL: begin
                if (ack) begin
                    state_d    = S_REQ;
                    fetch_pc_d = redir_pc_q;
                end
            end
            default: state_d = state_q;
        endcase

        // The outstanding address must stay on the bus, so the new PC is
        // parked in redir_pc_q until the pending request is acked.
        if (i_Redirect) begin
            if (req && !ack) begin
                state_d    = S_KILL;
                redir_pc_d = new_pc;
            end else begin
                state_d    = S_REQ;
                fetch_pc_d = new_pc;
            end
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        last_pc_d = last_pc_q;

        if (i_Redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                last_pc_d = pc_mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
            pend_q     <= pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_pc_q  <= last_pc_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= push_instr;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            fault_mem_q[wr_ptr_q] <= i_IBus_Err;
        end
    end

    always_comb begin
        o_IBus_Req    = req;
        o_IBus_Addr   = fetch_pc_q;
        o_Instr_Valid = valid;
        o_Instr       = valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
        o_Instr_PC    = valid ? pc_mem_q[rd_ptr_q] : last_pc_q;
        o_Fetch_Fault = valid && fault_mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: zero-wait bus model with per-cycle ack,
// data override and error injection; outputs checked 3 ns after each edge.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        err;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        valid;
    logic        fault;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;

    logic        ack_en;
    logic        ovr_en;
    logic [31:0] ovr;
    logic        err_en;
    logic [31:0] err_addr;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[19:0], 12'h093};
    endfunction

    assign ack  = req && ack_en;
    assign data = ovr_en ? ovr : mem_word(addr);
    assign err  = err_en && (addr == err_addr);

    instr_fetch dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_IBus_Req    (req),
        .o_IBus_Addr   (addr),
        .i_IBus_Ack    (ack),
        .i_IBus_Data   (data),
        .i_IBus_Err    (err),
        .o_Instr       (instr),
        .o_Instr_PC    (instr_pc),
        .o_Instr_Valid (valid),
        .o_Fetch_Fault (fault),
        .i_Stall       (stall),
        .i_Redirect    (redir),
        .i_Redirect_PC (redir_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = '0;
        ack_en = 1'b1; ovr_en = 1'b0; ovr = '0; err_en = 1'b0; err_addr = '0;

        // Reset and first fetch
        repeat (3) cyc();
        #1;
        chk("rst_req",   {31'd0, req},   32'd0);
        chk("rst_addr",  addr,           32'h0);
        chk("rst_instr", instr,          NOP);
        chk("rst_pc",    instr_pc,       32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;
        cyc(); #1;
        chk("first_req",  {31'd0, req}, 32'd1);
        chk("first_addr", addr,         32'h0);
        cyc();
        stall = 1'b1; #1;
        chk("first_valid", {31'd0, valid}, 32'd1);
        chk("first_instr", instr,          32'h0050_0093);
        chk("first_pc",    instr_pc,       32'h0);
        chk("next_addr",   addr,           32'h4);

        // Stall and backpressure: full after one more fetch
        cyc(); #1;
        chk("full_req",  {31'd0, req}, 32'd0);
        chk("full_addr", addr,         32'h8);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("stall_req",  {31'd0, req}, 32'd0);
            chk("stall_addr", addr,         32'h8);
            chk("stall_pc",   instr_pc,     32'h0);
        end
        cyc();
        stall = 1'b0; #1;
        chk("rel_pc0",  instr_pc,     32'h0);
        chk("rel_req",  {31'd0, req}, 32'd1);
        cyc(); #1;
        chk("rel_pc4",    instr_pc, 32'h4);
        chk("rel_instr4", instr,    32'h0000_4093);
        cyc();
        stall = 1'b1; redir = 1'b1; redir_pc = 32'h8; ack_en = 1'b0; #1;
        chk("rel_pc8",    instr_pc, 32'h8);
        chk("rel_instr8", instr,    32'h0000_8093);

        // Redirect while a request is pending
        cyc();
        redir = 1'b1; redir_pc = 32'h100; stall = 1'b0; #1;
        chk("pend_req",   {31'd0, req},   32'd1);
        chk("pend_addr",  addr,           32'h8);
        chk("pend_valid", {31'd0, valid}, 32'd0);
        cyc();
        redir = 1'b0; #1;
        chk("kill_req",   {31'd0, req}, 32'd1);
        chk("kill_addr",  addr,         32'h8);
        chk("kill_instr", instr,        NOP);
        cyc(); #1;
        chk("kill_addr2", addr, 32'h8);
        cyc();
        ovr_en = 1'b1; ovr = 32'hDEAD_BEEF; ack_en = 1'b1; #1;
        chk("kill_addr3", addr, 32'h8);
        cyc();
        ovr_en = 1'b0; #1;
        chk("post_kill_req",   {31'd0, req},   32'd1);
        chk("post_kill_addr",  addr,           32'h100);
        chk("post_kill_instr", instr,          NOP);
        chk("post_kill_valid", {31'd0, valid}, 32'd0);

        // Redirect with unaligned PC in the same cycle as an ack and a would-be pop
        cyc();
        redir = 1'b1; redir_pc = 32'h203; #1;
        chk("r100_valid", {31'd0, valid}, 32'd1);
        chk("r100_pc",    instr_pc,       32'h100);
        chk("r100_instr", instr,          32'h0010_0093);
        cyc();
        redir = 1'b0; #1;
        chk("flush_valid", {31'd0, valid}, 32'd0);
        chk("align_addr",  addr,           32'h200);
        chk("nopop_pc",    instr_pc,       32'h4);
        cyc();
        redir = 1'b1; redir_pc = 32'h40; err_en = 1'b1; err_addr = 32'h40; #1;
        chk("r200_pc",    instr_pc, 32'h200);
        chk("r200_instr", instr,    32'h0020_0093);

        // Bus error
        cyc();
        redir = 1'b0; #1;
        chk("err_req",  {31'd0, req}, 32'd1);
        chk("err_addr", addr,         32'h40);
        cyc(); #1;
        chk("fault_valid", {31'd0, valid}, 32'd1);
        chk("fault_flag",  {31'd0, fault}, 32'd1);
        chk("fault_instr", instr,          NOP);
        chk("fault_pc",    instr_pc,       32'h40);
        chk("halt_req",    {31'd0, req},   32'd0);
        cyc(); #1;
        chk("halt_valid", {31'd0, valid}, 32'd0);
        chk("halt_fault", {31'd0, fault}, 32'd0);
        chk("halt_req2",  {31'd0, req},   32'd0);
        cyc();
        err_en = 1'b0; redir = 1'b1; redir_pc = 32'h80; #1;
        chk("halt_req3", {31'd0, req}, 32'd0);
        cyc();
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC; #1;
        chk("resume_req",  {31'd0, req}, 32'd1);
        chk("resume_addr", addr,         32'h80);

        // Wrap
        cyc();
        redir = 1'b0; #1;
        chk("wrap_req",  {31'd0, req}, 32'd1);
        chk("wrap_addr", addr,         32'hFFFF_FFFC);
        cyc(); #1;
        chk("wrap_pc",    instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr,    32'hFFFF_C093);
        chk("wrap_next",  addr,     32'h0);
        cyc(); #1;
        chk("wrap_pc0",    instr_pc, 32'h0);
        chk("wrap_instr0", instr,    32'h0050_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit that supplies the instruction word, and its PC, to the main decode/control stage.
- Fetches from the instruction bus with a request/acknowledge handshake and buffers words in a small FIFO.
- Honours the decode stage's stall by holding the head entry.
- On a branch, jump or trap redirect, flushes the buffer and restarts at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, FIFO entries; power of two, at least 2.
- NOP_INSTR, 32'h0000_0013, word driven on o_Instr when nothing valid is presented (ADDI x0,x0,0).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- o_IBus_Req  out  1  fetch request.
- o_IBus_Addr  out  32  word-aligned fetch address.
- i_IBus_Ack  in  1  request accepted, data valid this cycle.
- i_IBus_Data  in  32  instruction word, qualified by ack.
- i_IBus_Err  in  1  bus error, qualified by ack.
- o_Instr  out  32  instruction to decode.
- o_Instr_PC  out  32  PC of o_Instr.
- o_Instr_Valid  out  1  head entry valid.
- o_Fetch_Fault  out  1  head entry is a fetch fault.
- i_Stall  in  1  decode stall; the head is not consumed.
- i_Redirect  in  1  flush and restart.
- i_Redirect_PC  in  32  restart address; bits [1:0] ignored.

Behaviour:
- **Single clock and reset.** One clock domain. Reset is synchronous, active-low, sampled on the rising edge of i_clk.
- **Reset values.**
  - o_IBus_Req=0, o_IBus_Addr=RESET_PC.
  - o_Instr=NOP_INSTR, o_Instr_PC=RESET_PC, o_Instr_Valid=0, o_Fetch_Fault=0.
  - FIFO empty, fetch_pc=RESET_PC, state S_IDLE.
- **Reset mid-transaction.** Reset at any time, including with a request outstanding, abandons that request. The bus side tolerates request withdrawal on reset only.
- **Bus handshake.**
  - At most one request outstanding.
  - Once o_IBus_Req rises, it and o_IBus_Addr stay stable until a cycle with i_IBus_Ack=1.
  - Data and error are sampled in that ack cycle (zero-cycle response). The request may drop or re-issue on the next cycle.
- **FSM.**
  - S_IDLE: goes to S_REQ the cycle after reset release.
  - S_REQ: asserts Req when free FIFO slots are at least 1, counting the entry being popped this cycle. On ack with no error, push {data, fetch_pc, 0} and set fetch_pc += 4. On ack with error, push {NOP_INSTR, fetch_pc, 1} and go to S_HALT.
  - S_KILL: a redirect arrived while a request was pending without ack. Keep Req and Addr stable. On ack, discard data and error, then go to S_REQ with fetch_pc = the latched redirect PC.
  - S_HALT: no requests. Leaves only on a redirect.
- **Redirect.** i_Redirect has priority over push, pop and stall in the same cycle.
  - The FIFO flushes.
  - fetch_pc is set to {i_Redirect_PC[31:2], 2'b00}.
  - If a request is pending and not acked this cycle, go to S_KILL.
  - If it is acked in the same cycle, drop the data and go to S_REQ.
  - A further redirect while in S_KILL overwrites the latched PC.
- **Decode side.**
  - The outputs reflect the FIFO head combinationally from registered state.
  - When the FIFO is empty: o_Instr=NOP_INSTR, Valid=0, Fault=0, o_Instr_PC = PC of the last popped entry.
  - Pop when Valid=1 and i_Stall=0 and i_Redirect=0.
  - Push and pop in the same cycle are allowed when full; the FIFO stays full.
- **Latency and throughput.**
  - Redirect to new-PC instruction valid: 2 cycles with a zero-wait bus (request cycle, then data registered).
  - Sustained throughput is 1 instruction per cycle when ack is immediate.
- **Boundaries.**
  - fetch_pc wraps from 32'hFFFF_FFFC to 0.
  - A full FIFO suppresses the request; the address is held.
  - A fault entry is presented once; popping it does not restart fetch.

Test Plan:
- **Reset and first fetch.** Reset 3 cycles, bus acks immediately with 0x00500093 at 0x0 -> Req at cycle 1 after release, Addr=0x0; then Valid=1, Instr=0x00500093, PC=0x0. Next Addr=0x4.
- **Stall and backpressure.** Stall held 6 cycles with bus always acking -> exactly 2 entries buffered. Req low while full, Addr held at 0x8. Head PC stays 0x0. On release, PCs 0x0, 0x4, 0x8 are delivered in consecutive cycles.
- **Redirect while pending.** Redirect to 0x100 while Req pending to 0x8, ack 3 cycles later with 0xDEADBEEF -> Addr stays 0x8 until ack, data is discarded, then Req with Addr=0x100. 0xDEADBEEF never appears on o_Instr.
- **Redirect alignment and priority.** Redirect to 0x203 in the same cycle as an ack, with stall=0 and Valid=1 -> FIFO flushed, next Addr=0x200, no pop side effects.
- **Bus error.** Ack with Err at 0x40 -> entry Valid=1, Fault=1, Instr=0x00000013, PC=0x40. No further Req until redirect to 0x80, then Req Addr=0x80.
- **Wrap.** Redirect to 0xFFFFFFFC -> fetches 0xFFFFFFFC, then 0x00000000.
